snn_debug_probe: RTL
====================

# snn_debug_probe

Parametrised debug probe for the SNN core: it selects one membrane potential or one layer spike vector and drives it onto a narrow registered debug port. Beyond the live multiplexer it adds three sequential modes: triggered snapshot, per-timestep auto-scan with frame marker, and a saturating spike counter. It sits between the SNN layers and the chip's shared debug output pins, and is configured through the same 8-bit config byte path.

## Interface
Parameters:
- N_NEURONS, 24, number of membrane potentials in the flattened input.
- MP_WIDTH, 5, bits per membrane potential; must be ≤ OUT_WIDTH.
- N_LAYERS, 3, number of spike layers.
- LAYER_WIDTH, 8, spikes per layer; must be ≤ OUT_WIDTH.
- OUT_WIDTH, 8, debug output width.
- Constraint: N_NEURONS+N_LAYERS ≤ 64 and N_LAYERS*LAYER_WIDTH ≤ 64.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- en  in  1  config write strobe.
- debug_config_in  in  8  [7:6] mode, [5:0] index.
- step  in  1  one-cycle pulse per SNN timestep.
- capture  in  1  snapshot trigger (HOLD mode).
- membrane_potentials  in  N_NEURONS*MP_WIDTH  neuron i at bits [i*MP_WIDTH +: MP_WIDTH].
- output_spikes  in  N_LAYERS*LAYER_WIDTH  layer l at [l*LAYER_WIDTH +: LAYER_WIDTH], layer 0 in the LSBs.
- debug_output  out  OUT_WIDTH  registered probe data.
- debug_valid  out  1  debug_output is meaningful.
- debug_frame  out  1  marks source 0 in SCAN mode.

## Operation
- Source map sel(k): k < N_NEURONS → potential k, zero-extended. N_NEURONS ≤ k < N_NEURONS+N_LAYERS → spikes of layer k−N_NEURONS, zero-extended. Otherwise → 0.
- Config register: 8 bits, loaded when en=1. Reset value 0, which is LIVE mode, index 0.
- Config write (en=1) at edge k:
  - Clears snapshot, scan pointer and counter.
  - Drives debug_output=0, debug_valid=0, debug_frame=0 at that edge.
  - The new mode governs from edge k+1.
  - en has priority: step and capture in the same cycle are ignored.
- Mode 00 LIVE: every edge, debug_output ← sel(index) and debug_valid ← 1.
- Mode 01 HOLD:
  - On capture=1, snapshot ← sel(index) and debug_valid ← 1 (sticky until the next config write or reset).
  - debug_output always shows the snapshot; it is 0 before the first capture.
- Mode 10 SCAN: index field ignored.
  - On step=1: debug_output ← sel(ptr), debug_valid ← 1 for one cycle, debug_frame ← (ptr==0).
  - ptr then increments and wraps from N_NEURONS+N_LAYERS−1 to 0.
  - Without step, debug_valid=0 and debug_frame=0; debug_output holds its last value.
- Mode 11 COUNT: index selects flat spike bit b of output_spikes.
  - On step=1 with output_spikes[b]=1, the counter increments and saturates at 2^OUT_WIDTH−1.
  - If b ≥ N_LAYERS*LAYER_WIDTH, the counter never increments.
  - debug_output = counter; debug_valid = 1.
- rst=1 at an edge: config=0; snapshot, ptr, counter cleared; debug_output=0, debug_valid=0, debug_frame=0. This applies mid-operation in any mode.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- LIVE latency: input change at cycle n is visible on debug_output after edge n+1.
- SCAN/COUNT/HOLD: the effect of step/capture sampled at edge n is visible immediately after edge n.
- Switching modes needs one flush cycle (outputs 0, valid 0) after the en edge.
- step held high for m cycles counts as m steps. Upstream guarantees single-cycle pulses.

## Test plan
- Reset, then en with config 0x05 and potential 5 = 0x13 → after 2 edges debug_output=0x13, debug_valid=1. Index 0x19 (layer 1 = 0xA5) → 0xA5. Index 0x3F → 0x00.
- HOLD 0x47 (potential 7), capture while potential 7 = 0x0B, then potential changes to 0x1F → output stays 0x0B, valid stays 1. Before the first capture, output is 0x00 with valid 0.
- SCAN 0x80, 28 step pulses → outputs follow sel(0..26) then sel(0). debug_frame pulses on the 1st and 28th step. valid is high only on step cycles.
- COUNT 0x8B|0x40 (=0xCB, bit 11 = layer 1 bit 3), held high over 300 steps → output saturates at 0xFF. Bit index 30 → output stays 0.
- en asserted together with step in SCAN → ptr resets to 0 and the step is ignored. rst pulsed mid-COUNT → all outputs 0 the next cycle and config returns to LIVE index 0.

Source files
------------

// File: rtl/snn_debug_probe_if.sv
// Probe-side bundle: config/strobe inputs, SNN state taps and the registered debug port.
interface snn_debug_probe_if #(
  parameter int N_NEURONS   = 24,
  parameter int MP_WIDTH    = 5,
  parameter int N_LAYERS    = 3,
  parameter int LAYER_WIDTH = 8,
  parameter int OUT_WIDTH   = 8
);
  logic                              en;
  logic [7:0]                        debug_config_in;
  logic                              step;
  logic                              capture;
  logic [N_NEURONS*MP_WIDTH-1:0]     membrane_potentials;
  logic [N_LAYERS*LAYER_WIDTH-1:0]   output_spikes;
  logic [OUT_WIDTH-1:0]              debug_output;
  logic                              debug_valid;
  logic                              debug_frame;

  modport master (
    output en, debug_config_in, step, capture, membrane_potentials, output_spikes,
    input  debug_output, debug_valid, debug_frame
  );

  modport slave (
    input  en, debug_config_in, step, capture, membrane_potentials, output_spikes,
    output debug_output, debug_valid, debug_frame
  );
endinterface

// File: rtl/snn_debug_probe.sv
// SNN debug probe: muxes one potential or spike layer onto a registered debug port,
// with LIVE / HOLD snapshot / SCAN sweep / COUNT saturating spike counter modes.
module snn_debug_probe #(
  parameter int N_NEURONS   = 24,
  parameter int MP_WIDTH    = 5,
  parameter int N_LAYERS    = 3,
  parameter int LAYER_WIDTH = 8,
  parameter int OUT_WIDTH   = 8
) (
  input logic              clk,
  input logic              rst,
  snn_debug_probe_if.slave bus
);
  localparam int N_SRC = N_NEURONS + N_LAYERS;

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_COUNT = 2'b11
  } mode_t;

  logic [7:0]           r_cfg;
  logic [5:0]           r_ptr;
  logic [OUT_WIDTH-1:0] r_cnt;
  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_valid;
  logic                 r_frame;

  mode_t                w_mode;
  logic [5:0]           w_idx;
  logic [63:0][OUT_WIDTH-1:0] w_src;
  logic [63:0]          w_spk_pad;
  logic                 w_hit;
  logic                 w_ptr_last;
  logic [OUT_WIDTH-1:0] w_cnt_nxt;

  assign w_mode = mode_t'(r_cfg[7:6]);
  assign w_idx  = r_cfg[5:0];

  // Full 64-entry source table; entries past the last layer read as zero.
  for (genvar k = 0; k < 64; k++) begin : g_src
    if (k < N_NEURONS) begin : g_mp
      assign w_src[k] = OUT_WIDTH'(bus.membrane_potentials[k*MP_WIDTH +: MP_WIDTH]);
    end else if (k < N_SRC) begin : g_ly
      assign w_src[k] = OUT_WIDTH'(bus.output_spikes[(k-N_NEURONS)*LAYER_WIDTH +: LAYER_WIDTH]);
    end else begin : g_zero
      assign w_src[k] = '0;
    end
  end

  // Zero padding makes out-of-range spike bit indices never count.
  assign w_spk_pad  = 64'(bus.output_spikes);
  assign w_hit      = w_spk_pad[w_idx];
  assign w_ptr_last = (r_ptr == 6'(N_SRC - 1));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (bus.step && w_hit && (r_cnt != {OUT_WIDTH{1'b1}}))
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
    end else if (bus.en) begin
      // Config write flushes all mode state; new mode takes over next edge.
      r_cfg   <= bus.debug_config_in;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      case (w_mode)
        MODE_LIVE: begin
          r_out   <= w_src[w_idx];
          r_valid <= 1'b1;
          r_frame <= 1'b0;
        end
        MODE_HOLD: begin
          // r_out doubles as the snapshot register; valid is sticky.
          r_frame <= 1'b0;
          if (bus.capture) begin
            r_out   <= w_src[w_idx];
            r_valid <= 1'b1;
          end
        end
        MODE_SCAN: begin
          r_valid <= 1'b0;
          r_frame <= 1'b0;
          if (bus.step) begin
            r_out   <= w_src[r_ptr];
            r_valid <= 1'b1;
            r_frame <= (r_ptr == 6'd0);
            r_ptr   <= w_ptr_last ? 6'd0 : r_ptr + 6'd1;
          end
        end
        MODE_COUNT: begin
          r_cnt   <= w_cnt_nxt;
          r_out   <= w_cnt_nxt;
          r_valid <= 1'b1;
          r_frame <= 1'b0;
        end
        default: begin
          r_out   <= '0;
          r_valid <= 1'b0;
          r_frame <= 1'b0;
        end
      endcase
    end
  end

  assign bus.debug_output = r_out;
  assign bus.debug_valid  = r_valid;
  assign bus.debug_frame  = r_frame;

endmodule
